// File: rtl/tdm_demux_if.sv
// Bus between the 7-channel TDM serial line driver and the tdm_demux receiver.
// The driver owns the beat/sync/data inputs; the receiver owns the channel and status outputs.
interface tdm_demux_if;
  logic       en_in;
  logic       sync_in;
  logic       data_in;
  logic       a_out;
  logic       b_out;
  logic       c_out;
  logic       d_out;
  logic       e_out;
  logic       f_out;
  logic       g_out;
  logic       frame_valid_out;
  logic       locked_out;
  logic       sync_err_out;
  logic [2:0] slot_out;

  modport master (
    output en_in, sync_in, data_in,
    input  a_out, b_out, c_out, d_out, e_out, f_out, g_out,
    input  frame_valid_out, locked_out, sync_err_out, slot_out
  );

  modport slave (
    input  en_in, sync_in, data_in,
    output a_out, b_out, c_out, d_out, e_out, f_out, g_out,
    output frame_valid_out, locked_out, sync_err_out, slot_out
  );
endinterface

// File: rtl/tdm_demux.sv
// Recovers seven single-bit channels from an 8-slot TDM serial line (slot 7 idle, must be 0),
// tracking frame alignment from a sync strobe and committing all channels together at frame end.
module tdm_demux #(
  parameter int MISS_LIMIT = 2
) (
  input  logic        clk,
  input  logic        rst,
  tdm_demux_if.slave  bus
);

  typedef enum logic {HUNT, LOCKED} state_t;

  localparam logic [2:0] MissLim = 3'(MISS_LIMIT);

  state_t     state_q, state_d;
  logic [2:0] slot_q, slot_d;
  logic [2:0] miss_q, miss_d;
  logic [6:0] shadow_q, shadow_d;
  logic [6:0] chan_q, chan_d;
  logic       fv_q, fv_d;
  logic       err_q, err_d;
  logic [2:0] miss_inc;

  assign miss_inc = miss_q + 3'd1;

  // State register: control, shadow buffer and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= HUNT;
      slot_q   <= 3'd0;
      miss_q   <= 3'd0;
      shadow_q <= 7'd0;
      chan_q   <= 7'd0;
      fv_q     <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      slot_q   <= slot_d;
      miss_q   <= miss_d;
      shadow_q <= shadow_d;
      chan_q   <= chan_d;
      fv_q     <= fv_d;
      err_q    <= err_d;
    end
  end

  // Next-state: alignment tracking, flywheel on missed sync, shadow capture
  always_comb begin
    state_d  = state_q;
    slot_d   = slot_q;
    miss_d   = miss_q;
    shadow_d = shadow_q;
    if (bus.en_in) begin
      if (state_q == HUNT) begin
        if (bus.sync_in) begin
          shadow_d[0] = bus.data_in;
          slot_d      = 3'd1;
          miss_d      = 3'd0;
          state_d     = LOCKED;
        end
      end else if (bus.sync_in) begin
        // Sync at any slot re-aligns; at slots 1..7 it also aborts the partial frame
        shadow_d[0] = bus.data_in;
        slot_d      = 3'd1;
        miss_d      = 3'd0;
      end else if (slot_q == 3'd0) begin
        if (miss_inc == MissLim) begin
          state_d  = HUNT;
          slot_d   = 3'd0;
          miss_d   = 3'd0;
          shadow_d = 7'd0;
        end else begin
          shadow_d[0] = bus.data_in;
          slot_d      = 3'd1;
          miss_d      = miss_inc;
        end
      end else if (slot_q == 3'd7) begin
        slot_d = 3'd0;
      end else begin
        shadow_d[slot_q] = bus.data_in;
        slot_d           = slot_q + 3'd1;
      end
    end
  end

  // Output: commit at a clean idle slot, flag early sync or a non-zero idle slot
  always_comb begin
    chan_d = chan_q;
    fv_d   = 1'b0;
    err_d  = 1'b0;
    if (bus.en_in && state_q == LOCKED) begin
      if (bus.sync_in) begin
        err_d = (slot_q != 3'd0);
      end else if (slot_q == 3'd7) begin
        if (bus.data_in) begin
          err_d = 1'b1;
        end else begin
          chan_d = shadow_q;
          fv_d   = 1'b1;
        end
      end
    end
  end

  assign bus.a_out           = chan_q[0];
  assign bus.b_out           = chan_q[1];
  assign bus.c_out           = chan_q[2];
  assign bus.d_out           = chan_q[3];
  assign bus.e_out           = chan_q[4];
  assign bus.f_out           = chan_q[5];
  assign bus.g_out           = chan_q[6];
  assign bus.frame_valid_out = fv_q;
  assign bus.locked_out      = (state_q == LOCKED);
  assign bus.sync_err_out    = err_q;
  assign bus.slot_out        = slot_q;

endmodule

// File: tb/tb_tdm_demux.sv
// Vector-table bench for tdm_demux: each record drives one cycle and carries the outputs
// expected one cycle later; expectations pass through a scoreboard queue before comparison.
module tb_tdm_demux;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  tdm_demux_if bus ();

  tdm_demux #(.MISS_LIMIT(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // exp packs {a..g (a is MSB), frame_valid, locked, sync_err, slot[2:0]}
  typedef struct {
    string      name;
    bit         rst;
    bit         en;
    bit         sync;
    bit         data;
    logic [12:0] exp;
  } vec_t;

  vec_t vec_q[$];
  vec_t exp_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  task automatic v(input string nm, input bit r, input bit e, input bit s, input bit d,
                   input logic [6:0] ch, input bit fv, input bit lk, input bit er,
                   input logic [2:0] sl);
    vec_t t;
    t.name = nm; t.rst = r; t.en = e; t.sync = s; t.data = d;
    t.exp  = {ch, fv, lk, er, sl};
    vec_q.push_back(t);
  endtask

  // One locked 8-beat frame starting at slot 0; 'gap' idle cycles with toggling inputs after each beat
  task automatic frame(input string nm, input bit sy, input logic [7:0] bits,
                       input logic [6:0] prev, input logic [6:0] commit,
                       input bit fv_last, input bit err_last, input int gap);
    for (int i = 0; i < 8; i++) begin
      logic [6:0] ch;
      ch = (i == 7) ? commit : prev;
      v(nm, 1'b0, 1'b1, (i == 0) ? sy : 1'b0, bits[7-i], ch,
        (i == 7) ? fv_last : 1'b0, 1'b1, (i == 7) ? err_last : 1'b0, 3'((i + 1) % 8));
      for (int k = 0; k < gap; k++)
        v({nm, "_gap"}, 1'b0, 1'b0, k[0] ? 1'b0 : 1'b1, ~bits[7-i], ch, 1'b0, 1'b1, 1'b0,
          3'((i + 1) % 8));
    end
  endtask

  task automatic check(input vec_t e);
    logic [12:0] got;
    got = {bus.a_out, bus.b_out, bus.c_out, bus.d_out, bus.e_out, bus.f_out, bus.g_out,
           bus.frame_valid_out, bus.locked_out, bus.sync_err_out, bus.slot_out};
    n_tests++;
    if (got !== e.exp) begin
      n_fail++;
      $display("FAIL %s: got a..g=%b fv=%b lk=%b err=%b slot=%0d, expected a..g=%b fv=%b lk=%b err=%b slot=%0d",
               e.name, got[12:6], got[5], got[4], got[3], got[2:0],
               e.exp[12:6], e.exp[5], e.exp[4], e.exp[3], e.exp[2:0]);
    end
  endtask

  initial begin
    rst = 1'b1;
    bus.en_in = 1'b0; bus.sync_in = 1'b0; bus.data_in = 1'b0;

    // Reset state
    v("reset", 1, 0, 0, 0, 7'b0000000, 0, 0, 0, 3'd0);
    v("reset_hold", 1, 1, 1, 1, 7'b0000000, 0, 0, 0, 3'd0);
    // HUNT ignores beats without sync and raises no error
    v("hunt_ignore", 0, 1, 0, 1, 7'b0000000, 0, 0, 0, 3'd0);
    // Clean frame 1,0,1,1,0,0,1,0
    frame("clean", 1, 8'b10110010, 7'b0000000, 7'b1011001, 1, 0, 0);
    v("clean_hold", 0, 0, 1, 1, 7'b1011001, 0, 1, 0, 3'd0);

    // Idle-slot error after a fresh reset
    v("idle_rst", 1, 0, 0, 0, 7'b0000000, 0, 0, 0, 3'd0);
    frame("idle_err", 1, 8'b10110011, 7'b0000000, 7'b0000000, 0, 1, 0);
    v("idle_after", 0, 0, 0, 0, 7'b0000000, 0, 1, 0, 3'd0);

    // Early sync at slot 4 re-aligns, then the re-aligned frame commits
    v("early_s0", 0, 1, 1, 1, 7'b0000000, 0, 1, 0, 3'd1);
    v("early_s1", 0, 1, 0, 0, 7'b0000000, 0, 1, 0, 3'd2);
    v("early_s2", 0, 1, 0, 0, 7'b0000000, 0, 1, 0, 3'd3);
    v("early_s3", 0, 1, 0, 0, 7'b0000000, 0, 1, 0, 3'd4);
    v("early_sync", 0, 1, 1, 1, 7'b0000000, 0, 1, 1, 3'd1);
    v("early_b1", 0, 1, 0, 0, 7'b0000000, 0, 1, 0, 3'd2);
    v("early_b2", 0, 1, 0, 1, 7'b0000000, 0, 1, 0, 3'd3);
    v("early_b3", 0, 1, 0, 1, 7'b0000000, 0, 1, 0, 3'd4);
    v("early_b4", 0, 1, 0, 1, 7'b0000000, 0, 1, 0, 3'd5);
    v("early_b5", 0, 1, 0, 1, 7'b0000000, 0, 1, 0, 3'd6);
    v("early_b6", 0, 1, 0, 1, 7'b0000000, 0, 1, 0, 3'd7);
    v("early_commit", 0, 1, 0, 0, 7'b1011111, 1, 1, 0, 3'd0);

    // Missed syncs: one good frame, one flywheel frame, then loss of lock
    frame("miss_good", 1, 8'b01010100, 7'b1011111, 7'b0101010, 1, 0, 0);
    frame("miss_fly", 0, 8'b11001100, 7'b0101010, 7'b1100110, 1, 0, 0);
    v("miss_lose", 0, 1, 0, 1, 7'b1100110, 0, 0, 0, 3'd0);
    for (int i = 0; i < 3; i++)
      v("miss_hunt", 0, 1, 0, 1, 7'b1100110, 0, 0, 0, 3'd0);

    // en_in gaps of 3 cycles with toggling inputs
    frame("gaps", 1, 8'b10110010, 7'b1100110, 7'b1011001, 1, 0, 3);

    // Reset mid-frame at slot 3, then a fresh frame
    v("mid_s0", 0, 1, 1, 1, 7'b1011001, 0, 1, 0, 3'd1);
    v("mid_s1", 0, 1, 0, 0, 7'b1011001, 0, 1, 0, 3'd2);
    v("mid_s2", 0, 1, 0, 1, 7'b1011001, 0, 1, 0, 3'd3);
    v("mid_rst", 1, 1, 1, 1, 7'b0000000, 0, 0, 0, 3'd0);
    frame("post_rst", 1, 8'b01101000, 7'b0000000, 7'b0110100, 1, 0, 0);
    v("post_hold", 0, 0, 0, 1, 7'b0110100, 0, 1, 0, 3'd0);

    @(posedge clk); #1;
    for (int i = 0; i < vec_q.size(); i++) begin
      rst         = vec_q[i].rst;
      bus.en_in   = vec_q[i].en;
      bus.sync_in = vec_q[i].sync;
      bus.data_in = vec_q[i].data;
      exp_q.push_back(vec_q[i]);
      @(posedge clk); #1;
      check(exp_q.pop_front());
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/tdm_demux.md
Name: tdm_demux

Overview:
- Receiving end of the team's 7-channel selector path. Recovers seven single-bit channels (a..g) from one time-division-multiplexed serial line.
- Frame layout: 8 slots. Slots 0..6 carry channels a..g. Slot 7 is a reserved idle slot that must be 0, matching the selector's sel=3'b111 → 0 encoding.
- Tracks frame alignment from a sync strobe, buffers a frame in shadow registers, and updates all seven outputs atomically at frame end.

Parameters:
- MISS_LIMIT, 2, consecutive frames with missing sync before losing lock; legal range 1..7.

Ports:
- clk  input  1  system clock, all logic on rising edge
- rst  input  1  synchronous, active-high reset
- en_in  input  1  beat strobe; data_in/sync_in sampled only when high
- sync_in  input  1  high on the slot-0 beat of every frame
- data_in  input  1  serial slot bit
- a_out..g_out  output  1 each  channel values from last committed frame
- frame_valid_out  output  1  one-cycle pulse when a..g_out update
- locked_out  output  1  high while in LOCKED state
- sync_err_out  output  1  one-cycle pulse on an alignment/idle-slot error
- slot_out  output  3  slot index expected on the next beat

Behaviour:
- Reset: a..g_out=0, frame_valid_out=0, locked_out=0, sync_err_out=0, slot_out=0. State=HUNT, miss counter=0, shadow=0. Reset wins over every other event, including mid-frame; a partial frame is discarded.
- Beat: a clock edge with en_in=1. With en_in=0, no state, counter or shadow changes; sync_in and data_in are ignored; pulses deassert.
- All outputs are registered. Every effect appears in the cycle after the beat that causes it.
- HUNT:
  - A beat with sync_in=0 is ignored.
  - A beat with sync_in=1 loads shadow[0]=data_in, sets slot=1, miss=0, moves to LOCKED; locked_out rises next cycle.
- LOCKED, beat at slot s, 1≤s≤6:
  - sync_in=0: shadow[s]=data_in; slot=s+1.
  - sync_in=1 (early sync): pulse sync_err_out. Discard the partial frame, re-align with this beat as slot 0 (shadow[0]=data_in, slot=1), miss=0. Stay LOCKED; nothing committed.
- LOCKED, beat at slot 7:
  - sync_in=1: handled as early sync.
  - data_in=1: pulse sync_err_out, commit nothing, slot=0.
  - data_in=0: copy shadow[0..6] to a..g_out together, pulse frame_valid_out, slot=0.
- LOCKED, beat at slot 0:
  - sync_in=1: shadow[0]=data_in, miss=0, slot=1.
  - sync_in=0 (missed sync): miss=miss+1.
    - New miss < MISS_LIMIT: flywheel. Accept the bit as slot 0 (shadow[0]=data_in, slot=1); the frame still commits normally.
    - New miss = MISS_LIMIT: go to HUNT, locked_out falls, slot=0, miss=0, shadow cleared. a..g_out hold their last committed values.
- Slot counter wraps 7→0 only through the slot-7 rules above.
- Outputs hold between commits. frame_valid_out never asserts in HUNT.
- No sync_err_out is raised in HUNT.

Test Plan:
- Clean frame: reset, then 8 consecutive beats with sync on beat 0, bits 1,0,1,1,0,0,1,0 → next cycle a..g_out=1,0,1,1,0,0,1; frame_valid_out high exactly 1 cycle; locked_out=1; slot_out=0.
- Idle-slot error: same frame with slot-7 bit=1 → sync_err_out 1-cycle pulse; a..g_out unchanged (0); no frame_valid_out; still locked.
- Early sync: lock, then sync_in=1 at slot 4 → sync_err_out pulse; slot_out=1 next cycle. The following 7 beats (bits 0,1,1,1,1,1,0) commit a..g=1(the sync beat's bit),0,1,1,1,1,1.
- Missed syncs, MISS_LIMIT=2: after one good frame, frame 2 without sync still commits with frame_valid_out. Frame 3 without sync → locked_out=0 after its slot-0 beat; a..g_out keep frame-2 values; later beats without sync are ignored.
- en_in gaps: clean frame with en_in low for 3 cycles between every beat, toggling data/sync during the gaps → result identical to the clean-frame case.
- Reset mid-frame: assert rst at slot 3 → all outputs 0 next cycle. Then a fresh aligned frame commits correctly with no sync_err_out.
